// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
// Read mode is selected at compile time by SYNC_FIFO_FWFT_EN:
//   defined   -> first-word-fall-through (rd_data shows the head word)
//   undefined -> registered read, 1-cycle latency, rd_valid pulses
module sync_fifo #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PTR_WIDTH     = 4,
    parameter int unsigned AFULL_THRESH  = 12,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    input  logic                  clr_err,
    output logic                  oflow,
    output logic                  uflow
);

    localparam int unsigned DEPTH = 2 ** PTR_WIDTH;

    localparam logic [PTR_WIDTH:0]   DEPTH_CNT  = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   AFULL_CNT  = (PTR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [PTR_WIDTH:0]   AEMPTY_CNT = (PTR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE    = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Status flags decode only the registered count, never the requests.
    always_comb begin
        full         = (count == DEPTH_CNT);
        empty        = (count == '0);
        almost_full  = (count >= AFULL_CNT);
        almost_empty = (count <= AEMPTY_CNT);
        wr_accept    = wr_en && !full;
        rd_accept    = rd_en && !empty;
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge aclk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; count tracks net occupancy change.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CNT_ONE;
            end else if (rd_accept && !wr_accept) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle takes priority.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            oflow <= 1'b0;
            uflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                oflow <= 1'b1;
            end else if (clr_err) begin
                oflow <= 1'b0;
            end
            if (rd_en && empty) begin
                uflow <= 1'b1;
            end else if (clr_err) begin
                uflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; rd_en acts as the pop.
    always_comb begin
        rd_data  = mem[rd_ptr];
        rd_valid = !empty;
    end
`else
    // Registered read: data loaded on the accepting edge, valid pulses once.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule
